// File: rtl/irq_arbiter.sv
// irq_arbiter: core-local trap controller.
//
// Latches NUM_IRQ interrupt sources and masks them with the per-source
// enable vector and mstatus.MIE. The lowest-indexed eligible source wins.
// In IDLE the block arbitrates between:
//   - synchronous exceptions (highest priority, held off while a jump or
//     divide start is in ex),
//   - asynchronous interrupts,
//   - mret (lowest priority).
// A trap entry writes mepc, mstatus and mcause on consecutive cycles and
// then pulses a pipeline redirect. An mret rewrites mstatus and then
// redirects to mepc. busy_o is high for the whole sequence so that the
// pipeline stalls.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   irq_i, irq_en_i       raw interrupt lines, per-source enable (mie)
//   sync_req_i            sync exception request from decode
//   sync_cause_i          sync exception code
//   mret_req_i            mret request from decode
//   ins_addr_i            pc of the instruction in decode
//   jump_flag_i           ex is taking a jump
//   jump_addr_i           jump target
//   div_req_i, div_busy_i divide start / divider busy
//   div_addr_i            pc of the in-flight divide
//   csr_mtvec_i           current mtvec
//   csr_mepc_i            current mepc
//   csr_mstatus_i         current mstatus
//   priv_i                current privilege level
//   csr_we_o              CSR write strobe
//   csr_waddr_o           CSR write address
//   csr_wdata_o           CSR write data
//   priv_we_o, priv_o     privilege write strobe and new privilege level
//   irq_pend_o            latched pending vector (mip mirror)
//   busy_o                trap/mret sequence in progress
//   int_assert_o          one-cycle redirect pulse
//   int_addr_o            redirect target
module irq_arbiter #(
  parameter int                 NUM_IRQ    = 8,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK  = '0,
  parameter int                 CAUSE_BASE = 16,
  parameter int                 XLEN       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               sync_req_i,
  input  logic [3:0]         sync_cause_i,
  input  logic               mret_req_i,
  input  logic [XLEN-1:0]    ins_addr_i,
  input  logic               jump_flag_i,
  input  logic [XLEN-1:0]    jump_addr_i,
  input  logic               div_req_i,
  input  logic               div_busy_i,
  input  logic [XLEN-1:0]    div_addr_i,
  input  logic [XLEN-1:0]    csr_mtvec_i,
  input  logic [XLEN-1:0]    csr_mepc_i,
  input  logic [XLEN-1:0]    csr_mstatus_i,
  input  logic [1:0]         priv_i,
  output logic               csr_we_o,
  output logic [11:0]        csr_waddr_o,
  output logic [XLEN-1:0]    csr_wdata_o,
  output logic               priv_we_o,
  output logic [1:0]         priv_o,
  output logic [NUM_IRQ-1:0] irq_pend_o,
  output logic               busy_o,
  output logic               int_assert_o,
  output logic [XLEN-1:0]    int_addr_o
);

  localparam int IDXW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    IDLE,
    MEPC,
    MSTATUS,
    MCAUSE,
    TRAP,
    MRET,
    RET
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_irqPrev;
  logic [NUM_IRQ-1:0] w_pendNext;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_elig;
  logic [IDXW-1:0]    w_winIdx;
  logic               w_anyIrq;

  logic               w_syncOk;
  logic               w_acceptSync;
  logic               w_acceptAsync;
  logic               w_acceptMret;
  logic [XLEN-1:0]    w_asyncEpc;
  logic [XLEN-1:0]    w_trapBase;

  logic [XLEN-1:0]    r_epc;
  logic [XLEN-1:0]    r_code;
  logic               r_isAsync;
  logic [IDXW-1:0]    r_irqIdx;

  // Mask pending sources and pick the lowest set index; scanning downward
  // lets the lowest index overwrite any higher one.
  always_comb begin
    w_elig   = r_pend & irq_en_i & {NUM_IRQ{csr_mstatus_i[3]}};
    w_anyIrq = |w_elig;
    w_winIdx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_winIdx = IDXW'(i);
      end
    end
  end

  // Arbitration happens only in IDLE. A sync exception is held off while
  // ex is redirecting or starting a divide, and in that window an
  // interrupt may still be taken.
  always_comb begin
    w_syncOk      = sync_req_i & ~(jump_flag_i | div_req_i);
    w_acceptSync  = (r_state == IDLE) & w_syncOk;
    w_acceptAsync = (r_state == IDLE) & ~w_syncOk & w_anyIrq;
    w_acceptMret  = (r_state == IDLE) & ~w_syncOk & ~w_anyIrq & mret_req_i;
  end

  // An interrupt must resume at the instruction that has not yet retired.
  // An in-flight divide takes precedence over a pending jump, and a
  // pending jump takes precedence over the pc in decode.
  always_comb begin
    if (div_req_i | div_busy_i) begin
      w_asyncEpc = div_addr_i;
    end else if (jump_flag_i) begin
      w_asyncEpc = jump_addr_i;
    end else begin
      w_asyncEpc = ins_addr_i;
    end
  end

  // Edge sources keep their pending bit until the trap for that source
  // reaches the mcause write. A new edge in the clearing cycle wins, so no
  // edge is lost. Level sources follow the line.
  always_comb begin
    w_clr = '0;
    if (r_state == MCAUSE && r_isAsync) begin
      w_clr[r_irqIdx] = 1'b1;
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (EDGE_MASK[i]) begin
        w_pendNext[i] = (r_pend[i] & ~w_clr[i]) | (irq_i[i] & ~r_irqPrev[i]);
      end else begin
        w_pendNext[i] = irq_i[i];
      end
    end
  end

  // Pending vector and the previous line value used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend    <= '0;
      r_irqPrev <= '0;
    end else begin
      r_pend    <= w_pendNext;
      r_irqPrev <= irq_i;
    end
  end

  // Capture the return address and cause at accept time. The inputs that
  // produced them may change while the sequence is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_epc     <= '0;
      r_code    <= '0;
      r_isAsync <= 1'b0;
      r_irqIdx  <= '0;
    end else if (w_acceptSync) begin
      r_epc     <= ins_addr_i;
      r_code    <= XLEN'(sync_cause_i);
      r_isAsync <= 1'b0;
    end else if (w_acceptAsync) begin
      r_epc     <= w_asyncEpc;
      r_code    <= XLEN'(CAUSE_BASE) + XLEN'(w_winIdx);
      r_isAsync <= 1'b1;
      r_irqIdx  <= w_winIdx;
    end
  end

  // State register. Reset drops straight to IDLE, which cancels any
  // sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state and the per-state CSR writes and redirect. In vectored
  // mode only interrupts index into the table; exceptions go to the base.
  always_comb begin
    w_stateNext  = r_state;
    csr_we_o     = 1'b0;
    csr_waddr_o  = '0;
    csr_wdata_o  = '0;
    priv_we_o    = 1'b0;
    priv_o       = 2'b11;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    w_trapBase   = {csr_mtvec_i[XLEN-1:2], 2'b00};
    case (r_state)
      IDLE: begin
        if (w_acceptSync || w_acceptAsync) begin
          w_stateNext = MEPC;
        end else if (w_acceptMret) begin
          w_stateNext = MRET;
        end
      end
      MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = r_epc;
        w_stateNext = MSTATUS;
      end
      MSTATUS: begin
        csr_we_o           = 1'b1;
        csr_waddr_o        = CSR_MSTATUS;
        csr_wdata_o        = csr_mstatus_i;
        csr_wdata_o[12:11] = priv_i;
        csr_wdata_o[7]     = csr_mstatus_i[3];
        csr_wdata_o[3]     = 1'b0;
        priv_we_o          = 1'b1;
        priv_o             = 2'b11;
        w_stateNext        = MCAUSE;
      end
      MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = r_isAsync ? {1'b1, r_code[XLEN-2:0]} : r_code;
        w_stateNext = TRAP;
      end
      TRAP: begin
        int_assert_o = 1'b1;
        if (csr_mtvec_i[1:0] == 2'b01 && r_isAsync) begin
          int_addr_o = w_trapBase + (r_code << 2);
        end else begin
          int_addr_o = w_trapBase;
        end
        w_stateNext = IDLE;
      end
      MRET: begin
        csr_we_o           = 1'b1;
        csr_waddr_o        = CSR_MSTATUS;
        csr_wdata_o        = csr_mstatus_i;
        csr_wdata_o[3]     = csr_mstatus_i[7];
        csr_wdata_o[7]     = 1'b1;
        csr_wdata_o[12:11] = 2'b00;
        priv_we_o          = 1'b1;
        priv_o             = csr_mstatus_i[12:11];
        w_stateNext        = RET;
      end
      RET: begin
        int_assert_o = 1'b1;
        int_addr_o   = csr_mepc_i;
        w_stateNext  = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign busy_o     = (r_state != IDLE);
  assign irq_pend_o = r_pend;

endmodule
